// File: rtl/nodf_module_intf.sv
// Passive ap_ctrl_hs status monitor: state, accept/complete counts, start-to-done latency.
// Latency: 1 clock from sampled handshake to registered outputs. Backpressure: none, never drives the block.
// Optional feature macro NODF_STALL_CNT_EN adds the stall_cycles counter; otherwise it is tied to 0.

// Generic circular FIFO with occupancy count; a push while full is accepted only alongside a pop.
// Latency: 1 clock from push to visible head. Backpressure: full/empty flags, caller gates in_vld.
// Storage is not reset; only pointers and count are.
module nodf_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_vld,
    input  logic [W-1:0]            in_dat,
    input  logic                    out_rdy,
    output logic [W-1:0]            out_dat,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_en   = out_rdy && !empty;
    assign wr_en   = in_vld && (!full || rd_en);
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= in_dat;
    end
endmodule

module nodf_module_intf #(
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic             protocol_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int AW = $clog2(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_next;
    logic [CNT_W-1:0] cyc;
    logic             finished;
    logic             active;
    logic             accept;
    logic             complete;
    logic             bypass;
    logic             push_en;
    logic             pop_en;
    logic             drop;
    logic             orphan;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [AW:0]      count_next;
    logic [CNT_W-1:0] head_dat;
    logic [CNT_W-1:0] lat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Everything stops one edge after finish is first sampled.
    assign active   = !finished;
    assign accept   = ap_start && ap_ready && active;
    assign complete = ap_done && ap_continue && active;
    assign bypass   = accept && complete && fifo_empty;
    assign pop_en   = complete && !fifo_empty;
    assign push_en  = accept && !bypass && (!fifo_full || pop_en);
    assign drop     = accept && !bypass && fifo_full && !pop_en;
    assign orphan   = complete && fifo_empty && !accept;
    assign lat      = cyc - head_dat;
    assign count_next = fifo_count + (AW+1)'(push_en) - (AW+1)'(pop_en);

    nodf_fifo #(
        .W     (CNT_W),
        .DEPTH (MAX_OUT)
    ) u_ts_fifo (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (push_en),
        .in_dat  (cyc),
        .out_rdy (pop_en),
        .out_dat (head_dat),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc          <= '0;
            finished     <= 1'b0;
            start_count  <= '0;
            done_count   <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            protocol_err <= 1'b0;
        end else if (active) begin
            cyc <= cyc + CNT_W'(1);
            if (finish)   finished    <= 1'b1;
            if (accept)   start_count <= sat_inc(start_count);
            if (complete) done_count  <= sat_inc(done_count);
            if (bypass) begin
                last_latency <= '0;
            end else if (pop_en) begin
                last_latency <= lat;
                if (lat > max_latency) max_latency <= lat;
            end
            if (drop || orphan) protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        if (finished || finish)         state_next = ST_FINISHED;
        else if (ap_done && !ap_continue) state_next = ST_STALL;
        else if (count_next != '0)      state_next = ST_BUSY;
    end

    assign status = state_q;

`ifdef NODF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                   stall_q <= '0;
        else if (active && ap_done && !ap_continue) stall_q <= sat_inc(stall_q);
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf: a vector table for the main sequence plus hand-written corner cases.
module tb_nodf_module_intf;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

`ifdef NODF_STALL_CNT_EN
    localparam int STALL_EXP = 3;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b1;
    logic        finish = 1'b0;
    logic [1:0]  status;
    logic [31:0] start_count;
    logic [31:0] done_count;
    logic [31:0] last_latency;
    logic [31:0] max_latency;
    logic        protocol_err;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       st;
        logic       rdy;
        logic       dn;
        logic       cont;
        logic       fin;
        int         rep;
        logic [1:0] status;
        int         sc;
        int         dc;
        int         ll;
        int         ml;
        logic       err;
    } vec_t;

    vec_t tbl[15];

    nodf_module_intf #(.CNT_W(32), .MAX_OUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .status       (status),
        .start_count  (start_count),
        .done_count   (done_count),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .protocol_err (protocol_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input int sc, input int dc,
                           input int ll, input int ml, input logic err);
        chk({tag, " status"}, 32'(status), 32'(st));
        chk({tag, " start_count"}, start_count, sc);
        chk({tag, " done_count"}, done_count, dc);
        chk({tag, " last_latency"}, last_latency, ll);
        chk({tag, " max_latency"}, max_latency, ml);
        chk({tag, " protocol_err"}, 32'(protocol_err), 32'(err));
    endtask

    // Drive at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic st, input logic rdy, input logic dn, input logic cont, input logic fin);
        @(negedge clock);
        ap_start = st;
        ap_ready = rdy;
        ap_done = dn;
        ap_continue = cont;
        finish = fin;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        ap_start = 1'b0;
        ap_ready = 1'b0;
        ap_done = 1'b0;
        ap_continue = 1'b1;
        finish = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_all("reset", S_IDLE, 0, 0, 0, 0, 1'b0);
        chk("reset stall_cycles", stall_cycles, 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        // st rdy dn cont fin rep | status sc dc ll ml err
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, S_IDLE, 0, 0, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, S_BUSY, 1, 0, 0, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6, S_BUSY, 1, 0, 0, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, S_IDLE, 1, 1, 7, 7, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, S_IDLE, 2, 2, 0, 7, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, S_BUSY, 3, 2, 0, 7, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, S_BUSY, 4, 3, 1, 7, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, S_BUSY, 4, 3, 1, 7, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, S_IDLE, 4, 4, 3, 7, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, S_IDLE, 4, 5, 3, 7, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, S_IDLE, 4, 5, 3, 7, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, S_STALL, 4, 5, 3, 7, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, S_FIN, 5, 5, 3, 7, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, S_FIN, 5, 5, 3, 7, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, S_FIN, 5, 5, 3, 7, 1'b1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            for (int r = 0; r < tbl[i].rep; r++)
                step(tbl[i].st, tbl[i].rdy, tbl[i].dn, tbl[i].cont, tbl[i].fin);
            chk_all($sformatf("vec%0d", i), tbl[i].status, tbl[i].sc, tbl[i].dc,
                    tbl[i].ll, tbl[i].ml, tbl[i].err);
        end

        // Five accepts into a four-deep FIFO, then drain four and one orphan completion.
        do_reset();
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("fill4", S_BUSY, 4, 0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("overflow", S_BUSY, 5, 0, 0, 0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("drain", S_IDLE, 5, 4, 5, 5, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("drain_orphan", S_IDLE, 5, 5, 5, 5, 1'b1);

        // Done held three cycles against ap_continue=0, then accepted.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("stall%0d status", k), 32'(status), 32'(S_STALL));
        end
        chk("stall done_count", done_count, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("stall_release", S_IDLE, 1, 1, 4, 4, 1'b0);
        chk("stall_cycles", stall_cycles, STALL_EXP);

        // Asynchronous reset in the middle of outstanding work.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("pre_abort", S_BUSY, 2, 0, 0, 0, 1'b0);
        @(negedge clock);
        ap_start = 1'b0;
        ap_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk_all("abort_async", S_IDLE, 0, 0, 0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("post_abort", S_IDLE, 1, 1, 1, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
